// File: rtl/r4_butter_seq.sv
// Sequencer for a shared radix-4 butterfly: holds one frame, issues four bin
// control words, and forwards the butterfly's registered results. Optional R4_SEQ_BITREV_EN.
module r4_butter_seq #(
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_frame,
    output logic [31:0] bf_x,
    output logic [2:0]  bf_c,
    input  logic [3:0]  bf_xro,
    input  logic [3:0]  bf_xio,
    output logic [3:0]  out_re,
    output logic [3:0]  out_im,
    output logic        out_valid,
    output logic [1:0]  out_bin,
    output logic [7:0]  frame_cnt
);

    localparam int unsigned GAP_EFF  = (GAP_CYCLES > 15) ? 15 : GAP_CYCLES;
    localparam logic [3:0]  GAP_LAST = 4'((GAP_EFF == 0) ? 0 : GAP_EFF - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ISSUE = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t      state, state_nx;
    logic [1:0]  slot, slot_nx;
    logic [3:0]  gap_cnt, gap_nx;
    logic        accept;
    logic        out_last;

    function automatic logic [1:0] order(input logic [1:0] k);
`ifdef R4_SEQ_BITREV_EN
        order = {k[0], k[1]};
`else
        order = k;
`endif
    endfunction

    function automatic logic [2:0] bin_code(input logic [1:0] b);
        case (b)
            2'd0:    bin_code = 3'b011;
            2'd1:    bin_code = 3'b101;
            2'd2:    bin_code = 3'b000;
            default: bin_code = 3'b110;
        endcase
    endfunction

    // in_ready is gated by RESET so it stays low for the whole reset window.
    assign in_ready = (state == IDLE) && RESET;
    assign out_re   = bf_xro;
    assign out_im   = bf_xio;

    always_comb begin
        state_nx = state;
        slot_nx  = slot;
        gap_nx   = gap_cnt;
        bf_c     = '0;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept   = 1'b1;
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                state_nx = ISSUE;
                slot_nx  = '0;
            end
            ISSUE: begin
                bf_c = bin_code(order(slot));
                if (slot == 2'd3) begin
                    gap_nx   = '0;
                    state_nx = (GAP_EFF == 0) ? IDLE : GAP;
                end else begin
                    slot_nx = slot + 2'd1;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_nx   = '0;
                    state_nx = IDLE;
                end else begin
                    gap_nx = gap_cnt + 4'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            state     <= IDLE;
            slot      <= '0;
            gap_cnt   <= '0;
            bf_x      <= '0;
            out_valid <= 1'b0;
            out_bin   <= '0;
            out_last  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state     <= state_nx;
            slot      <= slot_nx;
            gap_cnt   <= gap_nx;
            out_valid <= (state == ISSUE);
            out_last  <= (state == ISSUE) && (slot == 2'd3);
            if (accept)
                bf_x <= in_frame;
            if (state == ISSUE)
                out_bin <= order(slot);
            // Counted when the final bin's output cycle ends, not when it is issued.
            if (out_last)
                frame_cnt <= frame_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_r4_butter_seq.sv
// Self-checking bench for r4_butter_seq: directed scenarios plus randomized
// streaming against a schedule-based reference model, on GAP_CYCLES=0 and 3 instances.
module tb_r4_butter_seq;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b0;
    logic        in_valid_i [2];
    logic [31:0] in_frame_i [2];
    logic [3:0]  bf_xro_i   [2];
    logic [3:0]  bf_xio_i   [2];
    logic        in_ready_o [2];
    logic [31:0] bf_x_o     [2];
    logic [2:0]  bf_c_o     [2];
    logic [3:0]  out_re_o   [2];
    logic [3:0]  out_im_o   [2];
    logic        out_valid_o[2];
    logic [1:0]  out_bin_o  [2];
    logic [7:0]  frame_cnt_o[2];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 CLOCK = ~CLOCK;

    r4_butter_seq #(.GAP_CYCLES(0)) dut0 (
        .CLOCK(CLOCK), .RESET(RESET),
        .in_valid(in_valid_i[0]), .in_ready(in_ready_o[0]), .in_frame(in_frame_i[0]),
        .bf_x(bf_x_o[0]), .bf_c(bf_c_o[0]), .bf_xro(bf_xro_i[0]), .bf_xio(bf_xio_i[0]),
        .out_re(out_re_o[0]), .out_im(out_im_o[0]), .out_valid(out_valid_o[0]),
        .out_bin(out_bin_o[0]), .frame_cnt(frame_cnt_o[0])
    );

    r4_butter_seq #(.GAP_CYCLES(3)) dut3 (
        .CLOCK(CLOCK), .RESET(RESET),
        .in_valid(in_valid_i[1]), .in_ready(in_ready_o[1]), .in_frame(in_frame_i[1]),
        .bf_x(bf_x_o[1]), .bf_c(bf_c_o[1]), .bf_xro(bf_xro_i[1]), .bf_xio(bf_xio_i[1]),
        .out_re(out_re_o[1]), .out_im(out_im_o[1]), .out_valid(out_valid_o[1]),
        .out_bin(out_bin_o[1]), .frame_cnt(frame_cnt_o[1])
    );

    // Reference model: each accepted frame at edge A produces a fixed schedule
    // relative to A; the next accept is possible once 5+gap cycles have passed.
    int          cyc = 0;
    int          gapv     [2] = '{0, 3};
    int          ready_at [2] = '{1 << 30, 1 << 30};
    int          acc      [2] = '{-1000, -1000};
    int          cnt_edge [2] = '{-1, -1};
    logic [31:0] m_bfx    [2];
    logic [7:0]  m_cnt    [2];
    logic [1:0]  m_bin    [2];
    logic        m_valid  [2];
    logic [2:0]  m_c      [2];
    logic        saw255;

    function automatic int ord(input int k);
`ifdef R4_SEQ_BITREV_EN
        int tbl[4] = '{0, 2, 1, 3};
`else
        int tbl[4] = '{0, 1, 2, 3};
`endif
        return tbl[k];
    endfunction

    function automatic logic [2:0] code_of(input int b);
        case (b)
            0:       return 3'b011;
            1:       return 3'b101;
            2:       return 3'b000;
            default: return 3'b110;
        endcase
    endfunction

    function automatic void model_edge();
        int d;
        cyc = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (!RESET) begin
                ready_at[i] = cyc;
                acc[i]      = -1000;
                cnt_edge[i] = -1;
                m_bfx[i]    = '0;
                m_cnt[i]    = '0;
                m_bin[i]    = '0;
            end else begin
                if (cyc == cnt_edge[i])
                    m_cnt[i] = m_cnt[i] + 8'd1;
                if (in_valid_i[i] && (cyc - 1 >= ready_at[i])) begin
                    acc[i]      = cyc;
                    m_bfx[i]    = in_frame_i[i];
                    ready_at[i] = cyc + 5 + gapv[i];
                    cnt_edge[i] = cyc + 6;
                end
            end
            d          = cyc - acc[i];
            m_c[i]     = (d >= 1 && d <= 4) ? code_of(ord(d - 1)) : 3'b000;
            m_valid[i] = (d >= 2 && d <= 5);
            if (m_valid[i])
                m_bin[i] = 2'(ord(d - 2));
        end
    endfunction

    task automatic drive(input logic rst, input logic v0, input logic v1,
                         input logic [31:0] f0, input logic [31:0] f1);
        RESET         = rst;
        in_valid_i[0] = v0;
        in_valid_i[1] = v1;
        in_frame_i[0] = f0;
        in_frame_i[1] = f1;
        for (int i = 0; i < 2; i++) begin
            bf_xro_i[i] = 4'($urandom);
            bf_xio_i[i] = 4'($urandom);
        end
        model_edge();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic test_reset();
        for (int j = 0; j < 3; j++) begin
            drive(1'b0, 1'b1, 1'b1, $urandom, $urandom);
            n_chk++;
            if (in_ready_o[0] !== 1'b0) begin n_fail++; $display("FAIL reset.in_ready got %b exp 0", in_ready_o[0]); end
        end
        n_chk++;
        if (bf_x_o[0] !== 32'h0) begin n_fail++; $display("FAIL reset.bf_x got %h exp 0", bf_x_o[0]); end
        n_chk++;
        if (bf_c_o[0] !== 3'b000) begin n_fail++; $display("FAIL reset.bf_c got %b exp 000", bf_c_o[0]); end
        n_chk++;
        if (out_valid_o[0] !== 1'b0 || out_bin_o[0] !== 2'd0) begin
            n_fail++; $display("FAIL reset.out got v=%b bin=%0d exp v=0 bin=0", out_valid_o[0], out_bin_o[0]);
        end
        n_chk++;
        if (frame_cnt_o[0] !== 8'd0) begin n_fail++; $display("FAIL reset.frame_cnt got %0d exp 0", frame_cnt_o[0]); end
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        n_chk++;
        if (in_ready_o[0] !== 1'b1) begin n_fail++; $display("FAIL reset.release_ready got %b exp 1", in_ready_o[0]); end
    endtask

    task automatic test_single();
        logic [2:0] ec [4];
        int         eb [4];
`ifdef R4_SEQ_BITREV_EN
        ec = '{3'b011, 3'b000, 3'b101, 3'b110};
        eb = '{0, 2, 1, 3};
`else
        ec = '{3'b011, 3'b101, 3'b000, 3'b110};
        eb = '{0, 1, 2, 3};
`endif
        drive(1'b1, 1'b1, 1'b0, 32'h87654321, '0);
        for (int j = 0; j <= 6; j++) begin
            if (j > 0)
                drive(1'b1, 1'b0, 1'b0, $urandom, '0);
            n_chk++;
            if (bf_x_o[0] !== 32'h87654321) begin n_fail++; $display("FAIL single.bf_x E%0d got %h exp 87654321", j, bf_x_o[0]); end
            n_chk++;
            if (bf_c_o[0] !== ((j >= 1 && j <= 4) ? ec[j - 1] : 3'b000)) begin
                n_fail++; $display("FAIL single.bf_c E%0d got %b", j, bf_c_o[0]);
            end
            n_chk++;
            if (out_valid_o[0] !== (j >= 2 && j <= 5)) begin
                n_fail++; $display("FAIL single.out_valid E%0d got %b", j, out_valid_o[0]);
            end
            if (j >= 2 && j <= 5) begin
                n_chk++;
                if (out_bin_o[0] !== 2'(eb[j - 2])) begin
                    n_fail++; $display("FAIL single.out_bin E%0d got %0d exp %0d", j, out_bin_o[0], eb[j - 2]);
                end
                n_chk++;
                if (out_re_o[0] !== bf_xro_i[0] || out_im_o[0] !== bf_xio_i[0]) begin
                    n_fail++; $display("FAIL single.passthru E%0d got %h/%h exp %h/%h", j, out_re_o[0], out_im_o[0], bf_xro_i[0], bf_xio_i[0]);
                end
            end
            n_chk++;
            if (frame_cnt_o[0] !== ((j >= 6) ? 8'd1 : 8'd0)) begin
                n_fail++; $display("FAIL single.frame_cnt E%0d got %0d", j, frame_cnt_o[0]);
            end
        end
    endtask

    task automatic test_gap();
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        for (int j = 0; j <= 9; j++) begin
            drive(1'b1, 1'b1, 1'b1, 32'hA000_0000 + j, 32'hA000_0000 + j);
            if (j >= 1) begin
                n_chk++;
                if (in_ready_o[1] !== (j == 8)) begin n_fail++; $display("FAIL gap3.in_ready E%0d got %b exp %b", j, in_ready_o[1], j == 8); end
                n_chk++;
                if (in_ready_o[0] !== (j == 5)) begin n_fail++; $display("FAIL gap0.in_ready E%0d got %b exp %b", j, in_ready_o[0], j == 5); end
            end
            n_chk++;
            if (bf_x_o[1] !== ((j < 9) ? 32'hA000_0000 : 32'hA000_0009)) begin
                n_fail++; $display("FAIL gap3.bf_x E%0d got %h", j, bf_x_o[1]);
            end
            n_chk++;
            if (bf_x_o[0] !== ((j < 6) ? 32'hA000_0000 : 32'hA000_0006)) begin
                n_fail++; $display("FAIL gap0.bf_x E%0d got %h", j, bf_x_o[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, '0);
        for (int j = 1; j <= 3; j++)
            drive(1'b1, 1'b0, 1'b0, $urandom, '0);
        n_chk++;
        if (out_valid_o[0] !== 1'b1) begin n_fail++; $display("FAIL rstmid.pre_valid got %b exp 1", out_valid_o[0]); end
        drive(1'b0, 1'b1, 1'b0, $urandom, '0);
        n_chk++;
        if (out_valid_o[0] !== 1'b0 || bf_c_o[0] !== 3'b000) begin
            n_fail++; $display("FAIL rstmid.cancel got v=%b c=%b exp v=0 c=000", out_valid_o[0], bf_c_o[0]);
        end
        n_chk++;
        if (bf_x_o[0] !== 32'h0 || frame_cnt_o[0] !== 8'd0) begin
            n_fail++; $display("FAIL rstmid.clear got x=%h cnt=%0d exp x=0 cnt=0", bf_x_o[0], frame_cnt_o[0]);
        end
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        n_chk++;
        if (in_ready_o[0] !== 1'b1) begin n_fail++; $display("FAIL rstmid.ready got %b exp 1", in_ready_o[0]); end
        for (int j = 0; j < 4; j++) begin
            drive(1'b1, 1'b0, 1'b0, '0, '0);
            n_chk++;
            if (out_valid_o[0] !== 1'b0 || frame_cnt_o[0] !== 8'd0) begin
                n_fail++; $display("FAIL rstmid.after got v=%b cnt=%0d exp v=0 cnt=0", out_valid_o[0], frame_cnt_o[0]);
            end
        end
    endtask

    task automatic test_stream(input int ncyc, input int pct);
        for (int n = 0; n < ncyc; n++) begin
            drive(1'b1, ($urandom_range(99) < pct), ($urandom_range(99) < pct), $urandom, $urandom);
            for (int i = 0; i < 2; i++) begin
                if (frame_cnt_o[i] == 8'd255 && i == 0)
                    saw255 = 1'b1;
                n_chk++;
                if (in_ready_o[i] !== (cyc >= ready_at[i])) begin
                    n_fail++; $display("FAIL stream.in_ready inst%0d cyc%0d got %b exp %b", i, cyc, in_ready_o[i], cyc >= ready_at[i]);
                end
                n_chk++;
                if (bf_x_o[i] !== m_bfx[i]) begin
                    n_fail++; $display("FAIL stream.bf_x inst%0d cyc%0d got %h exp %h", i, cyc, bf_x_o[i], m_bfx[i]);
                end
                n_chk++;
                if (bf_c_o[i] !== m_c[i]) begin
                    n_fail++; $display("FAIL stream.bf_c inst%0d cyc%0d got %b exp %b", i, cyc, bf_c_o[i], m_c[i]);
                end
                n_chk++;
                if (out_valid_o[i] !== m_valid[i] || out_bin_o[i] !== m_bin[i]) begin
                    n_fail++; $display("FAIL stream.out inst%0d cyc%0d got v=%b bin=%0d exp v=%b bin=%0d",
                                       i, cyc, out_valid_o[i], out_bin_o[i], m_valid[i], m_bin[i]);
                end
                n_chk++;
                if (frame_cnt_o[i] !== m_cnt[i]) begin
                    n_fail++; $display("FAIL stream.frame_cnt inst%0d cyc%0d got %0d exp %0d", i, cyc, frame_cnt_o[i], m_cnt[i]);
                end
                n_chk++;
                if (out_re_o[i] !== bf_xro_i[i] || out_im_o[i] !== bf_xio_i[i]) begin
                    n_fail++; $display("FAIL stream.passthru inst%0d cyc%0d got %h/%h exp %h/%h",
                                       i, cyc, out_re_o[i], out_im_o[i], bf_xro_i[i], bf_xio_i[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        test_stream(40, 100);
        test_stream(200, 60);
    endtask

    task automatic test_wrap();
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        saw255 = 1'b0;
        test_stream(256 * 6, 100);
        test_stream(8, 0);
        n_chk++;
        if (frame_cnt_o[0] !== 8'd0) begin n_fail++; $display("FAIL wrap.frame_cnt got %0d exp 0", frame_cnt_o[0]); end
        n_chk++;
        if (saw255 !== 1'b1) begin n_fail++; $display("FAIL wrap.saw255 got %b exp 1", saw255); end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            in_valid_i[i] = 1'b0;
            in_frame_i[i] = '0;
            bf_xro_i[i]   = '0;
            bf_xio_i[i]   = '0;
            m_bfx[i]      = '0;
            m_cnt[i]      = '0;
            m_bin[i]      = '0;
            m_valid[i]    = 1'b0;
            m_c[i]        = '0;
        end
        saw255 = 1'b0;
        test_reset();
        test_single();
        test_gap();
        test_reset_mid();
        test_back_to_back();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/r4_butter_seq.md
R4_BUTTER_SEQ -- requirements
Module: r4_butter_seq

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 0, idle cycles inserted after each frame before in_ready re-asserts (0..15).
REQ-002 SHALL have port CLOCK  input  1  clock; all state updates on posedge.
REQ-003 SHALL have port RESET  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  frame offered.
REQ-005 SHALL have port in_ready  output  1  controller accepts frame this cycle.
REQ-006 SHALL have port in_frame  input  32  packed {xi3,xr3,xi2,xr2,xi1,xr1,xi0,xr0}, 4 bits each, xr0 at [3:0].
REQ-007 SHALL have port bf_x  output  32  held frame driven to butterfly sample inputs, same packing.
REQ-008 SHALL have port bf_c  output  3  butterfly controls {c1,c2,c3}.
REQ-009 SHALL have ports bf_xro, bf_xio  input  4 each  butterfly registered outputs.
REQ-010 SHALL have ports out_re, out_im  output  4 each  result bin real/imag.
REQ-011 SHALL have port out_valid  output  1  out_re/out_im/out_bin valid this cycle.
REQ-012 SHALL have port out_bin  output  2  bin index of current result.
REQ-013 SHALL have port frame_cnt  output  8  completed-frame count.

Function
REQ-014 SHALL implement states IDLE, LOAD, ISSUE, GAP; in_ready = 1 only in IDLE.
REQ-015 SHALL accept a frame on edge E0 when IDLE and in_valid=1, loading in_frame into bf_x and moving to LOAD.
REQ-016 SHALL hold bf_x constant from E0 until the next accepted frame.
REQ-017 SHALL stay in LOAD one cycle, then enter ISSUE with slot counter k=0 at E1.
REQ-018 SHALL in ISSUE slot k (cycle E(1+k)..E(2+k), k=0..3) drive bf_c per bin b=order(k): b0=011, b1=101, b2=000, b3=110.
REQ-019 SHALL drive bf_c=000 in IDLE, LOAD and GAP.
REQ-020 SHALL assert out_valid in cycle E(2+k)..E(3+k) with out_bin=order(k); out_re/out_im pass bf_xro/bf_xio through combinationally.
REQ-021 SHALL deassert out_valid in all other cycles; out_bin holds its last value then.
REQ-022 SHALL after slot 3 enter GAP for GAP_CYCLES cycles, or IDLE directly when GAP_CYCLES=0.
REQ-023 SHALL increment frame_cnt on the edge ending the bin-3 out_valid cycle; 255 wraps to 0.
REQ-024 SHALL give frame period 6+GAP_CYCLES cycles when in_valid is held high; bin-3 output of frame n overlaps the IDLE cycle of frame n+1.
REQ-025 SHALL ignore in_valid and in_frame outside IDLE; no frame is queued.
REQ-026 SHALL clamp GAP_CYCLES above 15 to 15.

Reset
REQ-027 SHALL on RESET=0 at a posedge force state IDLE, k=0, gap counter 0, bf_x=0, bf_c=000, out_valid=0, out_bin=0, frame_cnt=0.
REQ-028 SHALL hold in_ready=0 while RESET=0 and assert it the first cycle after release.
REQ-029 SHALL abandon any in-flight frame on reset mid-operation; pending out_valid pulses are cancelled.

Configuration
REQ-030 SHALL, with R4_SEQ_BITREV_EN defined, use order(k) = 0,2,1,3 (bit-reversed).
REQ-031 SHALL, without R4_SEQ_BITREV_EN, use order(k) = 0,1,2,3.

Verification
REQ-032 SHALL cover: reset, then in_valid=1 with in_frame=32'h87654321 at E0 -> bf_x=32'h87654321 from E0; bf_c 011,101,000,110 during E1..E5; out_valid E2..E6 with out_bin 0,1,2,3; frame_cnt=1 after E6.
REQ-033 SHALL cover: R4_SEQ_BITREV_EN defined, same stimulus -> bf_c 011,000,101,110; out_bin 0,2,1,3.
REQ-034 SHALL cover: in_valid held high, GAP_CYCLES=0, 3 frames -> accepts at E0, E6, E12; frame_cnt=3; bf_x changes only at accept edges.
REQ-035 SHALL cover: GAP_CYCLES=3 -> in_ready low for 3 extra cycles after slot 3; second accept at E9.
REQ-036 SHALL cover: RESET=0 during slot 2 -> next cycle out_valid=0, bf_c=000, bf_x=0, frame_cnt unchanged at 0; in_ready=1 the cycle after release.
REQ-037 SHALL cover: 256 frames -> frame_cnt wraps to 0; in_frame toggled while not IDLE -> bf_x unchanged.
